// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment reader: segment patterns
// for 0-F, field widths, sampler state encoding and a counter helper.
package seg7_pkg;

   localparam int DIGIT_W = 4;
   localparam int SEG_W   = 7;
   localparam int CNT_W   = 8;

   // Segment order is {g,f,e,d,c,b,a}: bit0 = a ... bit6 = g.
   localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_A = 7'h77;
   localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
   localparam logic [SEG_W-1:0] SEG_C = 7'h39;
   localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
   localparam logic [SEG_W-1:0] SEG_E = 7'h79;
   localparam logic [SEG_W-1:0] SEG_F = 7'h71;

   typedef enum logic [1:0] {
      ST_SETTLING = 2'd0,
      ST_CAPTURE  = 2'd1,
      ST_DWELL    = 2'd2
   } sampler_state_e;

   typedef struct packed {
      logic [DIGIT_W-1:0] value;
      logic               err;
   } decoded_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/seg7_reader_if.sv
// Bus between a multiplexed seven-segment source / frame consumer and the
// seg7_reader core. The DUT attaches to the slave modport.
interface seg7_reader_if #(
   parameter int NUM_DIGITS = 4
);
   import seg7_pkg::*;

   logic [SEG_W-1:0]              segments;
   logic [NUM_DIGITS-1:0]         digit_sel;
   logic                          frame_ready;
   logic                          frame_valid;
   logic [DIGIT_W*NUM_DIGITS-1:0] frame_digits;
   logic [NUM_DIGITS-1:0]         frame_err;
   logic                          overrun;

   modport master (
      output segments, digit_sel, frame_ready,
      input  frame_valid, frame_digits, frame_err, overrun
   );

   modport slave (
      input  segments, digit_sel, frame_ready,
      output frame_valid, frame_digits, frame_err, overrun
   );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of a BCD/hex-to-seven-segment encoder.
// Define SEG7_READER_HEX_EN to also accept the A-F glyphs as legal digits.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0]   pattern,
   output logic [DIGIT_W-1:0] value,
   output logic               err
);

`ifdef SEG7_READER_HEX_EN
   localparam bit HEX_EN = 1'b1;
`else
   localparam bit HEX_EN = 1'b0;
`endif

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the case can leave it unassigned and infer a latch.
      value = '0;
      err   = 1'b1;
      case (pattern)
         SEG_0: begin value = 4'h0; err = 1'b0; end
         SEG_1: begin value = 4'h1; err = 1'b0; end
         SEG_2: begin value = 4'h2; err = 1'b0; end
         SEG_3: begin value = 4'h3; err = 1'b0; end
         SEG_4: begin value = 4'h4; err = 1'b0; end
         SEG_5: begin value = 4'h5; err = 1'b0; end
         SEG_6: begin value = 4'h6; err = 1'b0; end
         SEG_7: begin value = 4'h7; err = 1'b0; end
         SEG_8: begin value = 4'h8; err = 1'b0; end
         SEG_9: begin value = 4'h9; err = 1'b0; end
         // Letter glyphs stay errors unless hex decoding is built in.
         SEG_A: if (HEX_EN) begin value = 4'hA; err = 1'b0; end
         SEG_B: if (HEX_EN) begin value = 4'hB; err = 1'b0; end
         SEG_C: if (HEX_EN) begin value = 4'hC; err = 1'b0; end
         SEG_D: if (HEX_EN) begin value = 4'hD; err = 1'b0; end
         SEG_E: if (HEX_EN) begin value = 4'hE; err = 1'b0; end
         SEG_F: if (HEX_EN) begin value = 4'hF; err = 1'b0; end
         default: begin value = '0; err = 1'b1; end
      endcase
   end

endmodule

// File: rtl/seg7_reader.sv
// Recovers digit values from a multiplexed seven-segment bus and presents them
// as valid/ready frames. Optional hex glyphs: define SEG7_READER_HEX_EN.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int STABLE_CYCLES  = 4,   // legal range 2..255
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   seg7_reader_if.slave  bus
);

   localparam int               SAMPLE_W   = NUM_DIGITS + SEG_W;
   localparam int               FRAME_W    = DIGIT_W * NUM_DIGITS;
   localparam logic [CNT_W-1:0] CAPTURE_AT = CNT_W'(STABLE_CYCLES - 1);

   // Sampler state
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   sampler_state_e      state_q, state_d;

   // Frame assembly and output register
   logic [DIGIT_W-1:0]    slot_val_q [NUM_DIGITS];
   logic [DIGIT_W-1:0]    slot_val_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] slot_err_q, slot_err_d;
   logic [NUM_DIGITS-1:0] mask_q, mask_d;
   logic                  valid_q, valid_d;
   logic [FRAME_W-1:0]    digits_q, digits_d;
   logic [NUM_DIGITS-1:0] ferr_q, ferr_d;
   logic                  overrun_q, overrun_d;

   logic [SAMPLE_W-1:0]   sample_in;
   logic                  changed;
   logic [NUM_DIGITS-1:0] sel;
   logic [SEG_W-1:0]      seg_raw;
   logic [SEG_W-1:0]      seg_pol;
   decoded_t              dec;
   logic                  capture;

   assign sample_in = {bus.digit_sel, bus.segments};
   assign changed   = (sample_in != sample_q);

   // Decode always works on the registered sample, which is what the
   // stability counter has been qualifying.
   assign sel     = sample_q[SAMPLE_W-1:SEG_W];
   assign seg_raw = sample_q[SEG_W-1:0];
   assign seg_pol = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

   seg7_pattern_decode u_decode (
      .pattern (seg_pol),
      .value   (dec.value),
      .err     (dec.err)
   );

   // ---------------------------------------------------------------- sampler
   always_comb begin
      sample_d = sample_in;
      cnt_d    = changed ? '0 : sat_inc(cnt_q);
      state_d  = state_q;
      if (changed) begin
         state_d = ST_SETTLING;
      end else begin
         case (state_q)
            ST_SETTLING: if (cnt_d == CAPTURE_AT) state_d = ST_CAPTURE;
            ST_CAPTURE:  state_d = ST_DWELL;
            ST_DWELL:    state_d = ST_DWELL;
            default:     state_d = ST_SETTLING;
         endcase
      end
   end

   // Zero or multiple strobes active means the bus is mid-transition: ignore.
   assign capture = (state_q == ST_CAPTURE) && $onehot(sel);

   // --------------------------------------------------------------- assembly
   always_comb begin
      slot_val_d = slot_val_q;
      slot_err_d = slot_err_q;
      mask_d     = mask_q;
      valid_d    = valid_q;
      digits_d   = digits_q;
      ferr_d     = ferr_q;
      overrun_d  = overrun_q;

      if (capture) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
               slot_val_d[i] = dec.value;
               slot_err_d[i] = dec.err;
               mask_d[i]     = 1'b1;
            end
         end
      end

      if (valid_q && bus.frame_ready) valid_d = 1'b0;

      // The completing capture is folded in this same cycle, which keeps the
      // final-digit latency at STABLE_CYCLES+1.
      if (&mask_d) begin
         mask_d = '0;
         if (!valid_q || bus.frame_ready) begin
            valid_d = 1'b1;
            ferr_d  = slot_err_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               digits_d[i*DIGIT_W +: DIGIT_W] = slot_val_d[i];
            end
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments only,
      // so every flop samples the pre-edge values regardless of block order.
      if (reset) begin
         sample_q   <= '0;
         cnt_q      <= '0;
         state_q    <= ST_SETTLING;
         mask_q     <= '0;
         slot_err_q <= '0;
         valid_q    <= 1'b0;
         digits_q   <= '0;
         ferr_q     <= '0;
         overrun_q  <= 1'b0;
         // NOTE: the slot array is reset explicitly rather than left as
         // uninitialised storage, so no stale digit can survive a reset.
         for (int i = 0; i < NUM_DIGITS; i++) slot_val_q[i] <= '0;
      end else begin
         sample_q   <= sample_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         mask_q     <= mask_d;
         slot_err_q <= slot_err_d;
         valid_q    <= valid_d;
         digits_q   <= digits_d;
         ferr_q     <= ferr_d;
         overrun_q  <= overrun_d;
         for (int i = 0; i < NUM_DIGITS; i++) slot_val_q[i] <= slot_val_d[i];
      end
   end

   assign bus.frame_valid  = valid_q;
   assign bus.frame_digits = digits_q;
   assign bus.frame_err    = ferr_q;
   assign bus.overrun      = overrun_q;

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter NUM_DIGITS, default 4, meaning: number of multiplexed digit positions.
REQ-002 Parameter STABLE_CYCLES, default 4, meaning: consecutive identical samples needed before a capture (legal range 2..255).
REQ-003 Parameter SEG_ACTIVE_LOW, default 0, meaning: 1 inverts segment inputs before decode.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 segments  input  7  sampled segment lines; bit0=a ... bit6=g.
REQ-007 digit_sel  input  NUM_DIGITS  one-hot digit strobe; bit i selects position i.
REQ-008 frame_valid  output  1  complete decoded frame available.
REQ-009 frame_ready  input  1  consumer accepts frame when high with frame_valid.
REQ-010 frame_digits  output  4*NUM_DIGITS  decoded values; nibble i belongs to position i.
REQ-011 frame_err  output  NUM_DIGITS  bit i set: pattern of position i not a legal digit.
REQ-012 overrun  output  1  sticky: a completed frame was discarded.

Function
REQ-013 Block SHALL be the reverse of the BCD-to-7-segment decoder: recover digit values from a multiplexed segment bus.
REQ-014 Sample register SHALL hold {digit_sel, segments} from previous cycle; stability counter SHALL reset to 0 on any difference, else increment, saturating.
REQ-015 Sampler FSM states SHALL be SETTLING, CAPTURE, DWELL; any change of sample -> SETTLING.
REQ-016 SETTLING -> CAPTURE when counter reaches STABLE_CYCLES-1; CAPTURE lasts exactly one cycle then -> DWELL; DWELL SHALL not capture again until the sample changes.
REQ-017 In CAPTURE, if digit_sel is one-hot, decoded value and error bit SHALL be written to slot i and mask bit i set; non-one-hot (including zero) SHALL be ignored.
REQ-018 Recapture of an already-masked slot SHALL overwrite it (latest value wins).
REQ-019 Legal patterns 0-9: 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F; any other pattern (blank 0x00 included) SHALL give value 0, error 1.
REQ-020 When mask is all ones and output register is empty or being accepted this cycle, slots SHALL load into frame_digits/frame_err, frame_valid SHALL be 1 next cycle, and mask SHALL clear.
REQ-021 frame_valid SHALL stay high and outputs stable until frame_valid && frame_ready; acceptance without a new load drops frame_valid next cycle.
REQ-022 Mask complete while output held (valid && !ready): assembly frame SHALL be discarded, mask cleared, overrun set until reset.
REQ-023 Latency: stable sample of final digit to frame_valid = STABLE_CYCLES+1 cycles.

Reset
REQ-024 Reset SHALL clear frame_valid, frame_digits, frame_err, overrun, mask, slots, counter, sample register; FSM -> SETTLING.
REQ-025 Reset mid-assembly or while frame_valid is high SHALL discard all partial/pending data; no frame appears until a full new set of captures.

Configuration
REQ-026 Macro SEG7_READER_HEX_EN defined: additionally decode 0x77=A,0x7C=b,0x39=C,0x5E=d,0x79=E,0x71=F with error 0.
REQ-027 Macro undefined: those six patterns SHALL decode as error (value 0, error 1).

Structure
REQ-028 Package seg7_pkg SHALL hold segment pattern constants for 0-F, digit width (4), and segment width (7).
REQ-029 Sub-module seg7_pattern_decode (combinational, pattern -> value, err, honours SEG7_READER_HEX_EN) SHALL be instantiated once after polarity inversion.

Verification
REQ-030 Drive positions 0..3 with 0x06,0x5B,0x4F,0x66, 6 cycles each, ready=1 -> one frame, frame_digits=0x4321, frame_err=0.
REQ-031 Hold 0x7F for only 3 cycles on position 2 (STABLE_CYCLES=4) -> no capture; mask bit 2 stays 0.
REQ-032 Present 0x77 on position 1 -> nibble 0xA, err 0 with SEG7_READER_HEX_EN; nibble 0, err bit 1 without.
REQ-033 ready=0, complete two frames -> first frame held unchanged, second discarded, overrun=1; ready pulse -> frame_valid 0.
REQ-034 Ready asserted in same cycle a new frame completes -> frame_valid stays 1, new data loaded, overrun stays 0.
REQ-035 Reset after two captures with frame_valid=1 -> all outputs 0 next cycle; next frame requires all four positions.
